pc_fetch_ctrl: RTL

- Per-core PC register and instruction-memory request sequencer sitting directly upstream of ins_fetch.
- Holds the architectural fetch PC and drives it to ins_fetch. Takes ins_fetch's PC+4 back as the sequential next PC.
- Issues one-at-a-time requests to the shared IMEM arbiter in the multi-core fabric.
- Buffers one returned instruction toward decode with valid/ready backpressure and branch-redirect flushing.

---
 rtl/pc_fetch_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register, one-outstanding IMEM request sequencer and single-entry instruction buffer
//   clk            core clock
//   rst            asynchronous active-low reset
//   pc_out         current fetch PC toward ins_fetch
//   pc_plus_4_in   sequential next PC from ins_fetch
//   imem_req/addr  request to the shared IMEM arbiter; imem_gnt accepts it
//   imem_rvalid    returned instruction word on imem_rdata
//   redirect_*     taken branch/jump target from EX, highest priority
//   if_valid/pc/instr, id_ready  buffered instruction toward decode
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus_4_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d, kill_q, kill_d, buf_free, fire;
    // Issue only when the buffer will have room by the time data returns
    assign buf_free  = !if_valid_q || id_ready;
    assign imem_req  = state_q == S_REQ && buf_free;
    assign fire      = imem_req && imem_gnt;
    assign pc_out    = pc_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        if_valid_d = (if_valid_q && id_ready) ? 1'b0 : if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'h3;
            if_valid_d = 1'b0;
            // A granted or still-pending request must have its response swallowed
            if (fire || (state_q == S_WAIT && !imem_rvalid)) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: if (fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_plus_4_in;
                    state_d  = S_WAIT;
                end
                S_WAIT: if (imem_rvalid) begin
                    if (!kill_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem_rdata;
                    end
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end
endmodule
